sig_axis_tx: RTL and testbench
==============================

SIG_AXIS_TX -- requirements
Module: sig_axis_tx

Interface
REQ-001 SHALL provide parameter PIXELS_PER_BEAT, default 16: pixel lanes per beat.
REQ-002 SHALL provide parameter IMAGE_DIM, default 512: image width and height in pixels.
REQ-003 SHALL provide parameter PIPE_LATENCY, default 4: number of unstalled cycles from in_valid to the matching sig_in beat.
REQ-004 SHALL provide parameter FIFO_DEPTH, default 8 (power of two, >=2): output skid FIFO depth in beats.
REQ-005 Ports, one per line (clock and reset first):
- clk  input  1  sole clock; all logic on rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  beat accepted into the sigma pipeline this cycle.
- sig_in  input  16*PIXELS_PER_BEAT  signed sigma pipeline result; 16-bit lane j at bits [j*16 +:16].
- stall  output  1  freezes the sigma pipeline and the upstream source.
- m_axis_tdata  output  16*PIXELS_PER_BEAT  AXI-Stream data.
- m_axis_tvalid  output  1  AXI-Stream valid.
- m_axis_tready  input  1  AXI-Stream ready.
- m_axis_tlast  output  1  last beat of the image.

Function
REQ-006 SHALL track beat validity with a PIPE_LATENCY-deep valid shift register, shifting in in_valid only on cycles with stall low; the tail bit is v_out.
REQ-007 On a cycle with stall low and v_out high, SHALL push sig_in into the FIFO; with stall high, SHALL NOT push (the held beat is not duplicated).
REQ-008 SHALL drive stall = (fifo_count == FIFO_DEPTH), combinationally from registered count only; no path from m_axis_tready to stall.
REQ-009 m_axis_tvalid SHALL equal (fifo_count != 0); tdata and tlast SHALL be the FIFO head; pop when tvalid & tready.
REQ-010 Once asserted, tvalid and tdata SHALL hold until the beat is accepted.
REQ-011 Simultaneous push and pop SHALL leave count unchanged, including at full (stall already high, so no push) and at empty (the beat is not bypassed; it appears next cycle).
REQ-012 Push-to-tvalid latency SHALL be exactly 1 cycle when the FIFO is empty.
REQ-013 SHALL count pushed beats modulo BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT; the push with count BEATS-1 SHALL store tlast=1 and wrap the counter to 0.
REQ-014 tdata SHALL be sig_in bit-exact; no resizing, saturation or sign change.
REQ-015 Bubbles (in_valid low) SHALL NOT advance the beat counter or push.

Reset
REQ-016 aresetn low SHALL asynchronously clear the valid shift register, the FIFO pointers and count, and the beat counter.
REQ-017 During reset: tvalid=0, tlast=0, stall=0; tdata is don't-care.
REQ-018 Reset mid-image SHALL discard in-flight and queued beats; the next pushed beat is beat 0 of a new image.
REQ-019 FIFO storage SHALL NOT be reset.

Configuration
REQ-020 Macro SIG_AXIS_TX_TUSER_EN: when defined, SHALL add output m_axis_tuser (1 bit), stored per beat, high on beat 0 of each image (start of frame).
REQ-021 Without SIG_AXIS_TX_TUSER_EN the port SHALL be absent and the function otherwise identical.

Structure
REQ-022 Shared package sig_pkg SHALL hold the lane width (16) and the BEATS-per-image computation.
REQ-023 The FIFO SHALL be a sub-module sig_tx_fifo (synchronous, parameterised width/depth, count output).

Verification
REQ-024 Continuous in_valid, tready=1, IMAGE_DIM=16, PIXELS_PER_BEAT=16: first tvalid PIPE_LATENCY+1 cycles after the first in_valid; 16 beats; tlast only on beat 15; stall never high.
REQ-025 tready=0 with continuous input: after FIFO_DEPTH pushes stall=1 and count=8; raise tready: one pop, stall drops next cycle, beats arrive in order with no loss or duplicate.
REQ-026 in_valid alternating 1/0: only valid beats emitted; the beat counter ignores bubbles; tlast on the 16th valid beat.
REQ-027 Assert aresetn low after beat 7 with 3 beats queued: tvalid=0 immediately; after release, the next beat is numbered 0 and tlast lands on the 16th.
REQ-028 Lane pattern 0x8000/0x7FFF/0xFFFF: tdata bit-exact.
REQ-029 SIG_AXIS_TX_TUSER_EN on, two back-to-back images: tuser=1 on beats 0 and 16 only.

Source files
------------

// File: rtl/sig_pkg.sv
// sig_pkg: shared constants and helpers for the sigma AXI-Stream transmit path.
//   LANE_W           width of one signed sigma lane
//   beats_per_image  beats needed to carry one IMAGE_DIM x IMAGE_DIM image
//   width_for        counter width able to hold 0..n-1 (never below 1 bit)
package sig_pkg;

  localparam int unsigned LANE_W = 16;

  function automatic int unsigned beats_per_image(input int unsigned dim,
                                                  input int unsigned ppb);
    return (dim * dim) / ppb;
  endfunction

  function automatic int unsigned width_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sig_tx_fifo.sv
// sig_tx_fifo: synchronous FIFO with occupancy count.
//   clk, rst_n     clock, asynchronous active-low reset (pointers/count only)
//   push/push_data write side; a push while full is ignored
//   pop/pop_data   read side; pop_data is the head word, a pop while empty is ignored
//   count          current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sig_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    pop_data = mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only words below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sig_axis_tx.sv
// sig_axis_tx: AXI-Stream transmitter for the sigma pipeline.
// Tracks beat validity alongside a PIPE_LATENCY-deep sigma pipeline, queues
// results in a skid FIFO, and stalls the pipeline when the FIFO is full.
//   clk, aresetn      clock, asynchronous active-low reset
//   in_valid          beat entering the sigma pipeline
//   sig_in            pipeline result, 16-bit signed lane j at [j*16 +: 16]
//   stall             freezes pipeline and source (FIFO full, registered only)
//   m_axis_*          AXI-Stream master; tlast marks the last beat of an image
//   m_axis_tuser      start-of-frame flag, present only with SIG_AXIS_TX_TUSER_EN
module sig_axis_tx
  import sig_pkg::*;
#(
  parameter int unsigned PIXELS_PER_BEAT = 16,
  parameter int unsigned IMAGE_DIM       = 512,
  parameter int unsigned PIPE_LATENCY    = 4,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic                              in_valid,
  input  logic [LANE_W*PIXELS_PER_BEAT-1:0] sig_in,
  output logic                              stall,
  output logic [LANE_W*PIXELS_PER_BEAT-1:0] m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
`ifdef SIG_AXIS_TX_TUSER_EN
  ,
  output logic                              m_axis_tuser
`endif
);

  localparam int unsigned DATA_W = LANE_W * PIXELS_PER_BEAT;
  localparam int unsigned BEATS  = beats_per_image(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int unsigned BEAT_W = width_for(BEATS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
`ifdef SIG_AXIS_TX_TUSER_EN
  localparam int unsigned FIFO_W = DATA_W + 2;
`else
  localparam int unsigned FIFO_W = DATA_W + 1;
`endif

  logic [PIPE_LATENCY-1:0] vld_q, vld_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    v_out, push, pop, last_beat;
  logic [CNT_W-1:0]        fifo_count;
  logic [FIFO_W-1:0]       push_word, head_word;

  always_comb begin
    stall     = (fifo_count == CNT_W'(FIFO_DEPTH));
    v_out     = vld_q[PIPE_LATENCY-1];
    push      = !stall && v_out;
    // Valid bits move only when the pipeline moves, so a held beat is pushed once.
    vld_d     = stall ? vld_q : ((vld_q << 1) | PIPE_LATENCY'(in_valid));
    last_beat = (beat_q == BEAT_W'(BEATS - 1));
    beat_d    = beat_q;
    if (push) beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
`ifdef SIG_AXIS_TX_TUSER_EN
    push_word = {(beat_q == '0), last_beat, sig_in};
`else
    push_word = {last_beat, sig_in};
`endif
    m_axis_tvalid = (fifo_count != '0);
    m_axis_tdata  = head_word[DATA_W-1:0];
    // Flags are qualified by tvalid since FIFO storage is not reset.
    m_axis_tlast  = m_axis_tvalid && head_word[DATA_W];
`ifdef SIG_AXIS_TX_TUSER_EN
    m_axis_tuser  = m_axis_tvalid && head_word[DATA_W+1];
`endif
    pop = m_axis_tvalid && m_axis_tready;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q  <= '0;
      beat_q <= '0;
    end else begin
      vld_q  <= vld_d;
      beat_q <= beat_d;
    end
  end

  sig_tx_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (aresetn),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head_word),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sig_axis_tx.sv
// tb_sig_axis_tx: scoreboard bench for sig_axis_tx (IMAGE_DIM=16, 16 lanes, 16 beats/image).
module tb_sig_axis_tx;
  import sig_pkg::*;

  localparam int unsigned PPB   = 16;
  localparam int unsigned DIM   = 16;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned BEATS = 16;
  localparam int unsigned DW    = LANE_W * PPB;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } exp_t;

  logic          clk;
  logic          aresetn;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [DW-1:0] sig_in;
  logic          stall;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
`ifdef SIG_AXIS_TX_TUSER_EN
  logic          m_axis_tuser;
`endif

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned tb_idx = 0;
  int unsigned accepted = 0;
  int unsigned tag = 0;
  longint      t_acc = 0;
  longint      t_acc0 = 0;
  longint      t_valid0 = 0;
  bit          lat_armed = 0;
  bit          watch_stall = 0;
  bit          stall_seen = 0;
  bit          hold_armed = 0;
  logic [DW-1:0] hold_data;
  logic [DW-1:0] pd [LAT];

  sig_axis_tx #(
    .PIXELS_PER_BEAT (PPB),
    .IMAGE_DIM       (DIM),
    .PIPE_LATENCY    (LAT),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .in_valid      (in_valid),
    .sig_in        (sig_in),
    .stall         (stall),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
`ifdef SIG_AXIS_TX_TUSER_EN
    ,
    .m_axis_tuser  (m_axis_tuser)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream sigma pipeline stand-in: data freezes together with the DUT's valid bits.
  always @(posedge clk) begin
    if (!stall) begin
      pd[0] <= in_data;
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end
  assign sig_in = pd[LAT-1];

  function automatic logic [DW-1:0] make_data(input int unsigned t);
    logic [DW-1:0] d;
    for (int j = 0; j < PPB; j++) begin
      case (j % 4)
        0:       d[j*16 +: 16] = 16'h8000;
        1:       d[j*16 +: 16] = 16'h7FFF;
        2:       d[j*16 +: 16] = 16'hFFFF;
        default: d[j*16 +: 16] = 16'(t) ^ 16'(j << 11);
      endcase
    end
    return d;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: protocol hold check plus scoreboard pop on every accepted beat.
  always @(negedge clk) begin
    if (!aresetn) begin
      hold_armed = 1'b0;
    end else begin
      if (watch_stall && stall) stall_seen = 1'b1;
      if (lat_armed && m_axis_tvalid) begin
        t_valid0  = $time;
        lat_armed = 1'b0;
      end
      if (hold_armed) begin
        checks++;
        if (!m_axis_tvalid || m_axis_tdata !== hold_data) begin
          errors++;
          $display("FAIL hold tvalid=%0b tdata=%h required tvalid=1 tdata=%h",
                   m_axis_tvalid, m_axis_tdata, hold_data);
        end
      end
      hold_armed = m_axis_tvalid && !m_axis_tready;
      hold_data  = m_axis_tdata;
      if (m_axis_tvalid && m_axis_tready) begin
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat tdata=%h required no beat", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.data) begin
            errors++;
            $display("FAIL tdata actual=%h required=%h", m_axis_tdata, e.data);
          end
          checks++;
          if (m_axis_tlast !== e.last) begin
            errors++;
            $display("FAIL tlast actual=%0b required=%0b", m_axis_tlast, e.last);
          end
`ifdef SIG_AXIS_TX_TUSER_EN
          checks++;
          if (m_axis_tuser !== e.user) begin
            errors++;
            $display("FAIL tuser actual=%0b required=%0b", m_axis_tuser, e.user);
          end
`endif
        end
      end
    end
  end

  task automatic send_beat();
    logic        s;
    int unsigned guard;
    bit          done;
    exp_t        e;
    guard    = 0;
    done     = 1'b0;
    tag++;
    in_valid = 1'b1;
    in_data  = make_data(tag);
    while (!done) begin
      @(negedge clk);
      s = stall;
      @(posedge clk);
      if (!s) begin
        e.data = make_data(tag);
        e.last = (tb_idx == BEATS - 1);
        e.user = (tb_idx == 0);
        exp_q.push_back(e);
        tb_idx   = (tb_idx + 1) % BEATS;
        accepted++;
        t_acc    = $time;
        done     = 1'b1;
      end else if (guard++ > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=stalled required=accepted");
        done = 1'b1;
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int unsigned g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(posedge clk);
      g++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    aresetn       = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    m_axis_tready = 1'b0;
    #12;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_stall", stall, 0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    idle(2);

    // Continuous stream, always ready: latency, 16 beats, no stall.
    m_axis_tready = 1'b1;
    lat_armed     = 1'b1;
    watch_stall   = 1'b1;
    stall_seen    = 1'b0;
    send_beat();
    t_acc0 = t_acc;
    for (int i = 1; i < 16; i++) send_beat();
    wait_drain("drain_stream");
    watch_stall = 1'b0;
    check("first_tvalid_time", t_valid0 - t_acc0, LAT * 10 + 5);
    check("stall_never", stall_seen, 0);

    // Backpressure: FIFO fills, stall, single pop releases stall for one cycle.
    idle(2);
    m_axis_tready = 1'b0;
    accepted      = 0;
    fork
      for (int i = 0; i < 16; i++) send_beat();
      begin
        repeat (30) @(posedge clk);
        #1;
        check("full_stall", stall, 1);
        check("full_tvalid", m_axis_tvalid, 1);
        check("full_accepted", accepted, DEPTH + LAT);
        m_axis_tready = 1'b1;
        @(negedge clk);
        check("pop_cycle_stall", stall, 1);
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        @(negedge clk);
        check("after_pop_stall", stall, 0);
        @(posedge clk);
        @(negedge clk);
        check("refill_stall", stall, 1);
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
      end
    join
    wait_drain("drain_backpressure");

    // Bubbles every other cycle: counter advances on valid beats only.
    for (int i = 0; i < 16; i++) begin
      send_beat();
      idle(1);
    end
    wait_drain("drain_bubbles");

    // Reset mid-image with three beats queued.
    for (int i = 0; i < 5; i++) send_beat();
    wait_drain("drain_pre_reset");
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat();
    idle(LAT + 3);
    check("queued_tvalid", m_axis_tvalid, 1);
    check("queued_left", exp_q.size(), 3);
    aresetn = 1'b0;
    exp_q.delete();
    tb_idx = 0;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tlast", m_axis_tlast, 0);
    check("midrst_stall", stall, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    aresetn       = 1'b1;
    m_axis_tready = 1'b1;
    idle(1);
    check("post_rst_tvalid", m_axis_tvalid, 0);
    for (int i = 0; i < 16; i++) send_beat();
    wait_drain("drain_post_reset");

    // Two back-to-back images.
    for (int i = 0; i < 32; i++) send_beat();
    wait_drain("drain_two_images");
    idle(3);
    check("end_tvalid", m_axis_tvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
